// File: rtl/gol_pkg.sv
// gol_pkg: grid geometry, pixel format and streamer state type shared by the Game-of-Life datapath
package gol_pkg;
    localparam int GRID_W = 1280;
    localparam int GRID_H = 720;
    localparam int ROW_ADDR_W = 10;
    localparam int PIXEL_W = 24;
    localparam logic [PIXEL_W-1:0] ALIVE_COLOUR = 24'hFFFFFF;
    localparam logic [PIXEL_W-1:0] DEAD_COLOUR = 24'h000000;
    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} stream_state_t;
endpackage

// File: rtl/grid_row_prefetch.sv
// grid_row_prefetch: current/next row registers with one-deep BRAM prefetch and line swap
module grid_row_prefetch import gol_pkg::*; #(
    parameter int WIDTH = GRID_W,
    parameter int HEIGHT = GRID_H,
    parameter int ADDR_W = ROW_ADDR_W
) (
    input logic clk,
    input logic rst_n,
    input logic kick,
    input logic swap,
    input logic clear,
    input logic [WIDTH-1:0] rd_data,
    output logic rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] cur_row,
    output logic cur_valid,
    output logic nxt_valid
);
    logic [WIDTH-1:0] nxt_row;
    logic [ADDR_W:0] next_addr;
    logic pend_cur, pend_nxt, want, issue;
    // a prefetch waits until the next-row slot is empty and nothing is in flight
    assign issue = want && !pend_nxt && !nxt_valid;
    assign rd_en = kick || issue;
    assign rd_addr = kick ? '0 : next_addr[ADDR_W-1:0];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cur_row <= '0;
            nxt_row <= '0;
            cur_valid <= 1'b0;
            nxt_valid <= 1'b0;
            pend_cur <= 1'b0;
            pend_nxt <= 1'b0;
            want <= 1'b0;
            next_addr <= '0;
        end else begin
            pend_cur <= kick;
            pend_nxt <= issue;
            if (kick) begin
                next_addr <= (ADDR_W+1)'(1);
                want <= HEIGHT > 1;
            end else if (issue) begin
                next_addr <= next_addr + 1'b1;
                want <= 1'b0;
            end else if (swap)
                want <= next_addr < (ADDR_W+1)'(HEIGHT);
            if (pend_cur) begin
                cur_row <= rd_data;
                cur_valid <= 1'b1;
            end else if (swap)
                cur_row <= nxt_row;
            if (pend_nxt) begin
                nxt_row <= rd_data;
                nxt_valid <= 1'b1;
            end else if (swap)
                nxt_valid <= 1'b0;
            if (clear) begin
                cur_valid <= 1'b0;
                nxt_valid <= 1'b0;
                want <= 1'b0;
            end
        end
endmodule

// File: rtl/grid_frame_streamer.sv
// grid_frame_streamer: streams one grid generation from BRAM as an AXI4-Stream RGB frame
module grid_frame_streamer import gol_pkg::*; #(
    parameter int WIDTH = GRID_W,
    parameter int HEIGHT = GRID_H,
    parameter int ADDR_W = ROW_ADDR_W,
    parameter logic [PIXEL_W-1:0] ALIVE_RGB = ALIVE_COLOUR,
    parameter logic [PIXEL_W-1:0] DEAD_RGB = DEAD_COLOUR
) (
    input logic out_stream_aclk,
    input logic out_stream_aresetn,
    input logic start,
    output logic busy,
    output logic frame_done,
    output logic rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input logic [WIDTH-1:0] rd_data,
    output logic [PIXEL_W-1:0] out_stream_tdata,
    output logic out_stream_tvalid,
    input logic out_stream_tready,
    output logic out_stream_tuser,
    output logic out_stream_tlast
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(HEIGHT - 1);
    stream_state_t state;
    logic [CW-1:0] col;
    logic [ADDR_W-1:0] row;
    logic [WIDTH-1:0] cur_row;
    logic tv, cur_valid, nxt_valid, kick, swap, xfer, eol;
    assign kick = state == IDLE && start;
    assign xfer = out_stream_tvalid && out_stream_tready;
    assign eol = col == LAST_COL;
    // !tv inside STREAM only happens while waiting at a line end for a late prefetch
    assign swap = state == STREAM && nxt_valid && row != LAST_ROW && ((xfer && eol) || !tv);
    grid_row_prefetch #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ADDR_W(ADDR_W)) u_prefetch (
        .clk(out_stream_aclk),
        .rst_n(out_stream_aresetn),
        .kick(kick),
        .swap(swap),
        .clear(state == DONE),
        .rd_data(rd_data),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .cur_row(cur_row),
        .cur_valid(cur_valid),
        .nxt_valid(nxt_valid)
    );
    always_ff @(posedge out_stream_aclk or negedge out_stream_aresetn)
        if (!out_stream_aresetn) begin
            state <= IDLE;
            busy <= 1'b0;
            frame_done <= 1'b0;
            tv <= 1'b0;
            col <= '0;
            row <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    busy <= 1'b1;
                    state <= LOAD;
                end
                LOAD: begin
                    tv <= 1'b1;
                    col <= '0;
                    row <= '0;
                    state <= STREAM;
                end
                STREAM: if (swap) begin
                    tv <= 1'b1;
                    col <= '0;
                    row <= row + 1'b1;
                end else if (xfer) begin
                    col <= eol ? '0 : col + 1'b1;
                    tv <= !eol;
                    if (eol && row == LAST_ROW) begin
                        busy <= 1'b0;
                        frame_done <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
            endcase
        end
    assign out_stream_tvalid = tv && cur_valid;
    assign out_stream_tdata = out_stream_tvalid ? (cur_row[col] ? ALIVE_RGB : DEAD_RGB) : '0;
    assign out_stream_tuser = out_stream_tvalid && row == '0 && col == '0;
    assign out_stream_tlast = out_stream_tvalid && eol;
endmodule

// File: tb/tb_grid_frame_streamer.sv
// tb_grid_frame_streamer: directed checks of an 8x4 and a 2x3 streamer against small BRAM images
module tb_grid_frame_streamer;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start_b = 1'b0, tready = 1'b0;
    always #5 clk = ~clk;

    logic busy, done, rd_en, tvalid, tuser, tlast;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [23:0] tdata;
    logic [7:0] mem [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    logic b_busy, b_done, b_rd_en, b_tvalid, b_tuser, b_tlast;
    logic [1:0] b_rd_addr, b_rd_data;
    logic [23:0] b_tdata;
    logic [1:0] bmem [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    always @(posedge clk) if (b_rd_en) b_rd_data <= bmem[b_rd_addr];

    grid_frame_streamer #(.WIDTH(8), .HEIGHT(4), .ADDR_W(2)) dut (
        .out_stream_aclk(clk), .out_stream_aresetn(rst_n), .start(start),
        .busy(busy), .frame_done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_stream_tdata(tdata), .out_stream_tvalid(tvalid), .out_stream_tready(tready),
        .out_stream_tuser(tuser), .out_stream_tlast(tlast));

    grid_frame_streamer #(.WIDTH(2), .HEIGHT(3), .ADDR_W(2)) dut_b (
        .out_stream_aclk(clk), .out_stream_aresetn(rst_n), .start(start_b),
        .busy(b_busy), .frame_done(b_done), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .out_stream_tdata(b_tdata), .out_stream_tvalid(b_tvalid), .out_stream_tready(tready),
        .out_stream_tuser(b_tuser), .out_stream_tlast(b_tlast));

    int total = 0, bad = 0;
    int cyc, npix, nrd, ndone, done_cyc, nfall, stab_bad, stall;
    logic [23:0] pd [64];
    logic pu [64], pl [64];
    int pc [64], ra [16];
    logic pbusy, prev_stall, prev_u, prev_l;
    logic [23:0] prev_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_rec();
        cyc = 0; npix = 0; nrd = 0; ndone = 0; done_cyc = -1; nfall = 0; stab_bad = 0; stall = 0;
        pbusy = 1'b0; prev_stall = 1'b0;
        for (int i = 0; i < 16; i++) ra[i] = -1;
    endtask

    // sample design A mid-cycle, then advance to just after the next rising edge
    task automatic step();
        @(negedge clk);
        if (rd_en && nrd < 16) begin ra[nrd] = int'(rd_addr); nrd++; end
        if (prev_stall && !(tvalid && tdata === prev_d && tuser === prev_u && tlast === prev_l)) stab_bad++;
        prev_stall = tvalid && !tready;
        prev_d = tdata; prev_u = tuser; prev_l = tlast;
        if (tvalid && tready && npix < 64) begin
            pd[npix] = tdata; pu[npix] = tuser; pl[npix] = tlast; pc[npix] = cyc; npix++;
        end
        if (done) begin ndone++; done_cyc = cyc; end
        if (pbusy && !busy) nfall++;
        pbusy = busy;
        @(posedge clk);
        #1 cyc++;
    endtask

    // mode 0: tready=1; mode 1: toggling tready plus a long stall; mode 2: stray start pulses
    task automatic frame(input int mode);
        logic [7:0] r;
        clear_rec();
        start = 1'b1;
        for (int k = 0; k < 400 && ndone == 0; k++) begin
            if (mode == 1) begin
                if (npix == 11 && stall < 20) begin tready = 1'b0; stall++; end
                else tready = (cyc % 2) == 0;
            end else tready = 1'b1;
            if (mode == 2 && (npix == 10 || npix == 32)) start = 1'b1;
            step();
            start = 1'b0;
        end
        for (int k = 0; k < 8; k++) step();
        chk("npix", 32'(npix), 32);
        for (int i = 0; i < 32; i++) begin
            r = mem[2'(i / 8)];
            chk("pixel", 32'(pd[i]), r[3'(i % 8)] ? 32'hFFFFFF : 32'h0);
            chk("tuser", 32'(pu[i]), 32'(i == 0));
            chk("tlast", 32'(pl[i]), 32'(i % 8 == 7));
        end
        chk("done_count", 32'(ndone), 1);
        chk("done_latency", 32'(done_cyc), 32'(pc[31] + 1));
        chk("rd_count", 32'(nrd), 4);
        for (int i = 0; i < 4; i++) chk("rd_addr", 32'(ra[i]), 32'(i));
        chk("busy_falls", 32'(nfall), 1);
        chk("stall_stable", 32'(stab_bad), 0);
        chk("idle_after", {30'd0, busy, tvalid}, 0);
        if (mode == 0) begin
            chk("first_valid", 32'(pc[0]), 2);
            chk("contiguous", 32'(pc[31] - pc[0]), 31);
        end
        if (mode == 1) chk("stall_seen", 32'(stall), 20);
    endtask

    logic [23:0] bd [8];
    logic bl [8];
    int nb, bub, bdone;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {busy, done, rd_en, rd_addr, tvalid, tuser, tlast, tdata}, 0);
        chk("reset_outputs_b", {b_busy, b_done, b_rd_en, b_rd_addr, b_tvalid, b_tuser, b_tlast, b_tdata}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame(0);
        frame(1);
        frame(2);

        clear_rec();
        start = 1'b1;
        tready = 1'b1;
        step();
        start = 1'b0;
        while (npix < 21 && cyc < 100) step();
        chk("pre_reset_pixel", {7'd0, tvalid, tdata}, {7'd0, 1'b1, 24'hFFFFFF});
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {busy, done, rd_en, rd_addr, tvalid, tuser, tlast, tdata}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        step();
        frame(0);

        nb = 0; bub = 0; bdone = 0;
        start_b = 1'b1;
        tready = 1'b1;
        for (int k = 0; k < 40 && bdone == 0; k++) begin
            @(negedge clk);
            if (b_tvalid && tready && nb < 8) begin bd[nb] = b_tdata; bl[nb] = b_tlast; nb++; end
            else if (b_busy && nb > 0 && nb < 6 && !bl[nb-1]) bub++;
            if (b_done) bdone++;
            @(posedge clk);
            #1 start_b = 1'b0;
        end
        chk("b_npix", 32'(nb), 6);
        chk("b_done", 32'(bdone), 1);
        chk("b_midline_bubbles", 32'(bub), 0);
        for (int i = 0; i < 6; i++) begin
            chk("b_pixel", 32'(bd[i]), (32'(bmem[2'(i / 2)]) >> (i % 2)) & 1 ? 32'hFFFFFF : 32'h0);
            chk("b_tlast", 32'(bl[i]), 32'(i % 2 == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/grid_frame_streamer.md
Name: grid_frame_streamer

Overview:
- Reads the completed Game-of-Life generation from the grid BRAM one row per word and emits it as an AXI4-Stream video frame (24-bit RGB), one cell per pixel.
- Counterpart to the next-state write path: that path writes rows into the grid BRAM; this block reads them back out.
- Sits between the grid BRAM read port and the out_stream master interface of the top level.
- Row prefetch keeps the stream bubble-free under backpressure.

Parameters:
- WIDTH, 1280, cells per row = bits per BRAM word = pixels per line
- HEIGHT, 720, rows per frame
- ADDR_W, 10, BRAM row address width; must satisfy 2^ADDR_W >= HEIGHT
- ALIVE_RGB, 24'hFFFFFF, pixel value for a live cell (bit = 1)
- DEAD_RGB, 24'h000000, pixel value for a dead cell (bit = 0)

Ports:
- out_stream_aclk  in  1  clock
- out_stream_aresetn  in  1  asynchronous active-low reset
- start  in  1  frame request pulse; sampled only in IDLE
- busy  out  1  high from accepted start until frame_done
- frame_done  out  1  one-cycle pulse after the final pixel handshake
- rd_en  out  1  BRAM read enable
- rd_addr  out  ADDR_W  BRAM row address
- rd_data  in  WIDTH  BRAM row data, valid the cycle after rd_en (1-cycle latency)
- out_stream_tdata  out  24  pixel RGB
- out_stream_tvalid  out  1  pixel valid
- out_stream_tready  in  1  sink ready
- out_stream_tuser  out  1  start of frame; high on pixel (0,0) only
- out_stream_tlast  out  1  end of line; high on column WIDTH-1

Behaviour:
- Reset (async, aresetn=0): state IDLE; busy=0, frame_done=0, rd_en=0, rd_addr=0, tvalid=0, tuser=0, tlast=0, tdata=0; both row registers marked empty; col=0, row=0.
- States:
  - IDLE: start=1 -> rd_en=1, rd_addr=0, busy=1, go to LOAD.
  - LOAD: capture rd_data into cur_row; set cur_valid; issue prefetch (rd_en=1, rd_addr=1) if HEIGHT>1; go to STREAM.
  - STREAM: drive pixels as below.
  - DONE: frame_done=1 for one cycle, busy=0, return to IDLE.
- Latency: first tvalid=1 occurs 2 cycles after the start cycle.
- Pixel mapping: tdata = cur_row[col] ? ALIVE_RGB : DEAD_RGB. Bit 0 is the leftmost pixel.
- Flags: tuser = (row==0 && col==0); tlast = (col==WIDTH-1).
- Handshake:
  - A transfer occurs when tvalid && tready.
  - While tvalid && !tready, tdata, tuser and tlast hold stable.
  - tvalid never drops without a transfer, except during reset.
- Prefetch:
  - Prefetched data lands in nxt_row the cycle after rd_en; set nxt_valid.
  - At most one outstanding read; rd_en is a single-cycle pulse.
  - The next prefetch (row+2) issues on the cycle after the swap.
- Line end: on the handshake at col=WIDTH-1:
  - If row==HEIGHT-1: tvalid=0 next cycle, go to DONE.
  - Else if nxt_valid: swap nxt_row->cur_row, row+1, col=0, clear nxt_valid, tvalid stays 1 (no bubble).
  - Else: tvalid=0 until nxt_valid, then resume. This only occurs when WIDTH<3.
- Counters:
  - col is clog2(WIDTH) bits and wraps to 0 at the line end.
  - row is ADDR_W bits and never exceeds HEIGHT-1.
  - rd_addr never exceeds HEIGHT-1; no read is issued beyond the last row.
- Boundary conditions:
  - start while busy: ignored; no restart, no queueing.
  - start in the same cycle as frame_done: ignored; a new start is needed in IDLE.
  - Reset mid-frame: all outputs return to reset values immediately; any in-flight BRAM read is discarded.
  - tready held low indefinitely: the block stalls with outputs frozen; the prefetched row is retained.

Decomposition:
- Shared package (gol_pkg): GRID_W=1280, GRID_H=720, ROW_ADDR_W=10, PIXEL_W=24, colour constants. The same constants size the line buffer and next-state write path.
- One natural sub-module: grid_row_prefetch, holding cur_row/nxt_row, valid flags, read issue and the swap. The top handles the FSM, counters and AXIS outputs.

Test Plan:
- WIDTH=8, HEIGHT=4, BRAM rows 8'h01, 8'h80, 8'hFF, 8'h00, tready=1, start pulse -> 32 transfers contiguous from cycle 2. Pixel(0,0)=FFFFFF with tuser=1; pixel(1,7)=FFFFFF; row 2 all FFFFFF; row 3 all 000000. tlast on transfers 8/16/24/32. frame_done pulses 1 cycle after transfer 32.
- Same frame, tready toggling 1010... plus a 20-cycle low stall at pixel (1,3) -> tdata/tuser/tlast stable during stalls; identical 32-pixel sequence; exactly 4 rd_en pulses with addresses 0,1,2,3.
- start re-pulsed at transfer 10, and again in the frame_done cycle -> no restart and no extra rd_en; busy drops exactly once.
- out_stream_aresetn asserted at pixel (2,5) -> all outputs 0 the same cycle. Next start yields a fresh frame beginning at row 0 with tuser=1.
- WIDTH=2, HEIGHT=3 -> tvalid bubbles permitted only at line boundaries; 6 transfers in order, tlast on every second transfer.
- Full-size 1280x720 glider pattern, random tready with 70% duty -> scoreboard matches the BRAM image; exactly 720 tlast, 1 tuser, 1 frame_done.
